// File: rtl/clk_seq_pkg.sv
// rtl/clk_seq_pkg.sv - shared mode encodings and state type for the clock-phase sequencer
package clk_seq_pkg;

    // Source select values on the mode input; 2'd3 is reserved and never starts a cycle.
    localparam logic [1:0] MODE_MANUAL = 2'd0;
    localparam logic [1:0] MODE_STEP   = 2'd1;
    localparam logic [1:0] MODE_RUN    = 2'd2;

    // IDLE: out=0 delayed=0 | PH1: out=1 delayed=0 | PH2: out=1 delayed=1 | LOW: out=0 delayed=0
    typedef enum logic [1:0] {
        IDLE,
        PH1,
        PH2,
        LOW
    } seq_state_t;

endpackage

// File: rtl/clk_seq_btn_debounce.sv
// rtl/clk_seq_btn_debounce.sv - button synchronizer with optional stability filter
//
// Optional feature macro: CLKSEQ_DEBOUNCE_EN
//   defined   : 2-flop synchronizer followed by a DEBOUNCE-sample stability counter
//   undefined : 2-flop synchronizer only (DEBOUNCE only range-checked)
//
// Ports:
//   clk   in  fast clock
//   rst   in  synchronous active-high reset
//   btn   in  asynchronous push-button
//   level out synchronized (and, when enabled, debounced) button level
module btn_debounce #(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level
);

    if (DEBOUNCE < 1) begin : g_bad_debounce
        $error("btn_debounce: DEBOUNCE must be at least 1");
    end

    logic sync1;
    logic sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

`ifdef CLKSEQ_DEBOUNCE_EN
    // Counter holds 0..DEBOUNCE-1 consecutive disagreeing samples.
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [CW-1:0] stable_cnt;

    // The level flips on the DEBOUNCE-th consecutive sample that disagrees with it;
    // any agreeing sample restarts the count, so shorter glitches vanish.
    always_ff @(posedge clk) begin
        if (rst) begin
            level      <= 1'b0;
            stable_cnt <= '0;
        end else if (sync2 == level) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CW'(DEBOUNCE - 1)) begin
            level      <= sync2;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end
`else
    assign level = sync2;
`endif

endmodule

// File: rtl/clk_sequencer.sv
// rtl/clk_sequencer.sv - comp16 CPU clock-phase sequencer (manual / step / run sources)
//
// Optional feature macro: CLKSEQ_DEBOUNCE_EN (button debounce inside btn_debounce)
//
// Ports:
//   clk        in  fast FPGA clock
//   rst        in  synchronous active-high reset
//   mode       in  source select (MANUAL / STEP / RUN, 3 = no cycles)
//   btn        in  asynchronous manual clock button
//   step_req   in  rising edge starts one cycle in STEP mode
//   div        in  high/low phase length H = div + 1 for STEP/RUN
//   hlt        in  blocks the start of new cycles
//   out        out primary CPU clock
//   delayed    out CPU clock delayed by DELAY fast cycles
//   busy       out a CPU clock cycle is in progress
//   cycle_done out pulse in the last fast cycle of each CPU clock cycle
module clk_sequencer
    import clk_seq_pkg::*;
#(
    parameter int DELAY    = 7,
    parameter int DIV_W    = 16,
    parameter int DEBOUNCE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             btn,
    input  logic             step_req,
    input  logic [DIV_W-1:0] div,
    input  logic             hlt,
    output logic             out,
    output logic             delayed,
    output logic             busy,
    output logic             cycle_done
);

    if (DELAY < 1 || DELAY > 15) begin : g_bad_delay
        $error("clk_sequencer: DELAY must be in 1..15");
    end

    // One extra bit so div = all-ones gives H = 2^DIV_W without wrapping.
    localparam int CW = DIV_W + 1;

    seq_state_t    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] h_len;
    logic [CW-1:0] div_h;
    logic [1:0]    mode_l;
    logic          btn_level;
    logic          btn_level_q;
    logic          step_q;
    logic          btn_rise;
    logic          step_rise;
    logic          start;
    logic          run_again;
    logic          ph1_last;
    logic          h_last;

    btn_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_btn (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .level (btn_level)
    );

    assign btn_rise  = btn_level & ~btn_level_q;
    assign step_rise = step_req & ~step_q;
    assign div_h     = {1'b0, div} + CW'(1);
    assign ph1_last  = (cnt == CW'(DELAY - 1));
    assign h_last    = (cnt == h_len - CW'(1));
    // Back-to-back only when the cycle was started in RUN and RUN is still selected.
    assign run_again = (mode_l == MODE_RUN) && (mode == MODE_RUN) && !hlt;

    always_comb begin
        start = 1'b0;
        if (!hlt) begin
            case (mode)
                MODE_MANUAL: start = btn_rise;
                MODE_STEP:   start = step_rise;
                MODE_RUN:    start = 1'b1;
                default:     start = 1'b0;
            endcase
        end
    end

    // Outputs are assigned together with each state transition so they always
    // reflect the state being entered. Edge registers run in every state, so
    // step edges seen while busy are simply lost rather than queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            h_len       <= '0;
            mode_l      <= MODE_MANUAL;
            btn_level_q <= 1'b0;
            step_q      <= 1'b0;
            out         <= 1'b0;
            delayed     <= 1'b0;
            busy        <= 1'b0;
            cycle_done  <= 1'b0;
        end else begin
            btn_level_q <= btn_level;
            step_q      <= step_req;
            cycle_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= PH1;
                        cnt    <= '0;
                        mode_l <= mode;
                        h_len  <= div_h;
                        out    <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                PH1: begin
                    // A manual release wins over the end of PH1, so delayed never rises.
                    if (mode_l == MODE_MANUAL && !btn_level) begin
                        state      <= IDLE;
                        out        <= 1'b0;
                        busy       <= 1'b0;
                        cycle_done <= 1'b1;
                    end else if (ph1_last) begin
                        state   <= PH2;
                        cnt     <= '0;
                        delayed <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PH2: begin
                    if (mode_l == MODE_MANUAL) begin
                        if (!btn_level) begin
                            state      <= IDLE;
                            out        <= 1'b0;
                            delayed    <= 1'b0;
                            busy       <= 1'b0;
                            cycle_done <= 1'b1;
                        end
                    end else if (h_last) begin
                        state      <= LOW;
                        cnt        <= '0;
                        out        <= 1'b0;
                        delayed    <= 1'b0;
                        // With H = 1 the first LOW cycle is also the last one.
                        cycle_done <= (h_len == CW'(1));
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LOW: begin
                    if (h_last) begin
                        if (run_again) begin
                            state  <= PH1;
                            cnt    <= '0;
                            mode_l <= mode;
                            h_len  <= div_h;
                            out    <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt        <= cnt + 1'b1;
                        cycle_done <= (cnt + CW'(2) == h_len);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_sequencer.sv
// tb/tb_clk_sequencer.sv - scoreboard testbench for clk_sequencer
module tb_clk_sequencer;
    import clk_seq_pkg::*;

    localparam int DELAY    = 7;
    localparam int DIV_W    = 4;
    localparam int DEBOUNCE = 4;
`ifdef CLKSEQ_DEBOUNCE_EN
    localparam int LAT = 2 + DEBOUNCE;
`else
    localparam int LAT = 2;
`endif

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic [1:0]       mode     = MODE_STEP;
    logic             btn      = 1'b0;
    logic             step_req = 1'b0;
    logic [DIV_W-1:0] div      = '0;
    logic             hlt      = 1'b0;
    logic             out;
    logic             delayed;
    logic             busy;
    logic             cycle_done;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_fail = 0;
    int n_rise = 0;
    int n_done = 0;

    typedef struct {
        int start;
        int out_len;
        int dly_len;
        int done_off;
        int busy_len;
    } rec_t;

    rec_t exp_q[$];

    clk_sequencer #(
        .DELAY    (DELAY),
        .DIV_W    (DIV_W),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .btn        (btn),
        .step_req   (step_req),
        .div        (div),
        .hlt        (hlt),
        .out        (out),
        .delayed    (delayed),
        .busy       (busy),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Timed STEP/RUN cycle: out DELAY+H, delayed H, LOW H, done in last LOW cycle.
    task automatic push_timed(input int start, input int h);
        rec_t r;
        r.start    = start;
        r.out_len  = DELAY + h;
        r.dly_len  = h;
        r.done_off = DELAY + 2 * h - 1;
        r.busy_len = DELAY + 2 * h;
        exp_q.push_back(r);
    endtask

    // Manual cycle: out follows the filtered button; done in the first idle cycle.
    task automatic push_manual(input int start, input int hold);
        rec_t r;
        r.start    = start;
        r.out_len  = hold;
        r.dly_len  = (hold > DELAY) ? hold - DELAY : 0;
        r.done_off = hold;
        r.busy_len = hold;
        exp_q.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 300) begin
            tick();
            k++;
        end
        check({name, "_idle_timeout"}, int'(busy), 0);
    endtask

    task automatic step_pulse(output int t);
        tick();
        t = cyc;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
    endtask

    task automatic manual_press(input int hold);
        int t;
        tick();
        t = cyc;
        btn = 1'b1;
        push_manual(t + LAT + 1, hold);
        wait_cyc(t + hold);
        btn = 1'b0;
        wait_cyc(t + hold + LAT + 3);
        wait_idle("manual");
        repeat (DEBOUNCE + 2) tick();
    endtask

    // Monitor: measures each CPU clock cycle and checks it against the queue head.
    initial begin : monitor
        bit   in_rec;
        int   st, ol, dl, bl, idx;
        logic prev_out;
        rec_t e;
        in_rec = 0; st = 0; ol = 0; dl = 0; bl = 0; idx = 0; prev_out = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_rec   = 0;
                prev_out = out;
            end else begin
                if (out && !prev_out) begin
                    n_rise++;
                    in_rec = 1;
                    st = cyc; ol = 0; dl = 0; bl = 0;
                end
                if (in_rec) begin
                    ol += int'(out);
                    dl += int'(delayed);
                    bl += int'(busy);
                end
                if (cycle_done) begin
                    n_done++;
                    if (!in_rec || exp_q.size() == 0) begin
                        check("unexpected_cycle_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("rec%0d_start", idx),    st,       e.start);
                        check($sformatf("rec%0d_out_len", idx),  ol,       e.out_len);
                        check($sformatf("rec%0d_dly_len", idx),  dl,       e.dly_len);
                        check($sformatf("rec%0d_done_off", idx), cyc - st, e.done_off);
                        check($sformatf("rec%0d_busy_len", idx), bl,       e.busy_len);
                        idx++;
                    end
                    in_rec = 0;
                end
                prev_out = out;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int t, s, s3, u, nr, nd, kind, h, hold;

        // Reset state
        repeat (3) tick();
        check("reset_out",        int'(out),        0);
        check("reset_delayed",    int'(delayed),    0);
        check("reset_busy",       int'(busy),       0);
        check("reset_cycle_done", int'(cycle_done), 0);
        rst = 1'b0;
        tick();

        // STEP, div=3; a second request while busy is ignored
        mode = MODE_STEP;
        div  = DIV_W'(3);
        tick();
        step_pulse(t);
        push_timed(t + 1, 4);
        wait_cyc(t + 5);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        wait_idle("step_directed");

        // hlt blocks a step start and the edge is not remembered afterwards
        hlt = 1'b1;
        nr  = n_rise;
        step_pulse(t);
        repeat (10) tick();
        hlt = 1'b0;
        repeat (20) tick();
        check("hlt_blocks_step", n_rise - nr, 0);

        // MANUAL: release before DELAY elapses, then a long hold
        mode = MODE_MANUAL;
        tick();
        manual_press(5);
        manual_press(12);

        // MANUAL glitch of 3 cycles
        tick();
        nr  = n_rise;
        t   = cyc;
        btn = 1'b1;
`ifndef CLKSEQ_DEBOUNCE_EN
        push_manual(t + LAT + 1, 3);
`endif
        repeat (3) tick();
        btn = 1'b0;
        repeat (20) tick();
`ifdef CLKSEQ_DEBOUNCE_EN
        check("glitch_rejected", n_rise - nr, 0);
`else
        check("glitch_passes", n_rise - nr, 1);
`endif
        wait_idle("glitch");

        // Randomized STEP / MANUAL mix with boundary div values first
        for (int i = 0; i < 10; i++) begin
            kind = (i < 2) ? 0 : int'($urandom_range(0, 1));
            repeat (int'($urandom_range(1, 4))) tick();
            if (kind == 0) begin
                mode = MODE_STEP;
                if (i == 0)      div = '1;
                else if (i == 1) div = '0;
                else             div = DIV_W'($urandom_range(0, 15));
                h = int'(div) + 1;
                tick();
                step_pulse(t);
                push_timed(t + 1, h);
                if ($urandom_range(0, 1) == 1) begin
                    tick();
                    step_req = 1'b1;
                    tick();
                    step_req = 1'b0;
                end
                if ($urandom_range(0, 1) == 1) div = DIV_W'($urandom_range(0, 15));
                wait_idle("step_rand");
            end else begin
                mode = MODE_MANUAL;
                tick();
                hold = int'($urandom_range(DEBOUNCE, 16));
                manual_press(hold);
            end
        end

        // Reset in the middle of PH2: outputs drop, no cycle_done
        mode = MODE_STEP;
        div  = DIV_W'(3);
        tick();
        step_pulse(t);
        wait_cyc(t + 9);
        rst = 1'b1;
        nd  = n_done;
        tick();
        check("midrst_out",        int'(out),        0);
        check("midrst_delayed",    int'(delayed),    0);
        check("midrst_busy",       int'(busy),       0);
        check("midrst_cycle_done", int'(cycle_done), 0);
        rst = 1'b0;
        repeat (30) tick();
        check("midrst_no_done", n_done - nd, 0);

        // RUN, div=1 (period 11); div change mid-cycle; hlt mid-PH2; restart
        mode = MODE_STEP;
        tick();
        div  = DIV_W'(1);
        mode = MODE_RUN;
        t    = cyc;
        s    = t + 1;
        push_timed(s, 2);
        push_timed(s + 11, 2);
        wait_cyc(s + 13);
        div = DIV_W'(4);
        s3  = s + 22;
        push_timed(s3, 5);
        wait_cyc(s3 + 8);
        hlt = 1'b1;
        wait_cyc(s3 + 30);
        check("hlt_holds_idle", int'(busy), 0);
        hlt = 1'b0;
        u   = cyc;
        push_timed(u + 1, 5);
        wait_cyc(u + 3);
        mode = 2'd3;
        wait_idle("run_stop");

        // Reserved mode never starts a cycle
        nr = n_rise;
        step_pulse(t);
        repeat (40) tick();
        check("mode3_no_start", n_rise - nr, 0);

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
